// File: rtl/branch_sequencer_pkg.sv
// Shared widths and state encoding for the instruction fetch sequencer.
package branch_sequencer_pkg;
  localparam int PC_W    = 10;
  localparam int INSTR_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    HOLD   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } seq_state_e;
endpackage

// File: rtl/branch_sequencer_if.sv
// Fetch, decode-handoff and branch-redirect signals between the sequencer and its neighbours.
interface branch_sequencer_if;
  import branch_sequencer_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0]    instr_pc;
  logic               dec_ready;
  logic               br_valid;
  logic               br_taken;
  logic [PC_W-1:0]    br_target;
  logic               halt;
  logic               flush;
  logic               halted;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, instr_pc, flush, halted,
    input  imem_ack, imem_data, dec_ready, br_valid, br_taken, br_target, halt
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, instr_pc, flush, halted,
    output imem_ack, imem_data, dec_ready, br_valid, br_taken, br_target, halt
  );
endinterface

// File: rtl/branch_sequencer.sv
// Fetch sequencer: one outstanding imem request, single-entry decode holding register,
// branch redirect with drain of an in-flight fetch, and a sticky halt.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 10'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_sequencer_if.master bus
);

  seq_state_e         state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    tgt;
  logic [PC_W-1:0]    instrPc;
  logic [INSTR_W-1:0] instrOut;
  logic               imemReq;
  logic               instrValid;
  logic               flushQ;
  logic               haltedQ;
  logic               redirect;

  assign redirect = bus.br_valid & bus.br_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      tgt        <= '0;
      instrPc    <= '0;
      instrOut   <= '0;
      imemReq    <= 1'b0;
      instrValid <= 1'b0;
      flushQ     <= 1'b0;
      haltedQ    <= 1'b0;
    end else begin
      flushQ <= 1'b0;
      case (state)
        IDLE: begin
          state   <= FETCH;
          imemReq <= 1'b1;
        end
        FETCH: begin
          if (redirect) begin
            flushQ <= 1'b1;
            // Data arriving with the redirect is wrong-path; refetch right away.
            if (bus.imem_ack) begin
              pc <= bus.br_target;
            end else begin
              tgt   <= bus.br_target;
              state <= DRAIN;
            end
          end else if (bus.imem_ack) begin
            instrOut   <= bus.imem_data;
            instrPc    <= pc;
            pc         <= pc + 1'b1;
            instrValid <= 1'b1;
            imemReq    <= 1'b0;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (redirect) begin
            flushQ     <= 1'b1;
            instrValid <= 1'b0;
            pc         <= bus.br_target;
            imemReq    <= 1'b1;
            state      <= FETCH;
          end else if (bus.dec_ready) begin
            instrValid <= 1'b0;
            if (bus.halt) begin
              haltedQ <= 1'b1;
              state   <= HALTED;
            end else begin
              imemReq <= 1'b1;
              state   <= FETCH;
            end
          end
        end
        DRAIN: begin
          // The old request stays on the bus until memory answers; its data is dropped.
          if (redirect) begin
            flushQ <= 1'b1;
            tgt    <= bus.br_target;
          end
          if (bus.imem_ack) begin
            pc    <= redirect ? bus.br_target : tgt;
            state <= FETCH;
          end
        end
        HALTED: ;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.imem_req    = imemReq;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = instrValid;
  assign bus.instr_out   = instrOut;
  assign bus.instr_pc    = instrPc;
  assign bus.flush       = flushQ;
  assign bus.halted      = haltedQ;

endmodule
